alu_issue: RTL and testbench
============================

# alu_issue

Decode-and-issue pipeline stage that sits directly upstream of the ALU. It accepts one raw MIPS instruction per cycle together with its register-file read data. It translates the instruction into the ALU's 5-bit op code, operands and shift amount, and holds the result in a single-entry output register with a valid/ready handshake. It also enforces a one-cycle load-use interlock and keeps a saturating count of interlock stall cycles.

## Interface
- STALL_W, 16, width of the stall-cycle counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; one clock, no other clock domains
- flush  in  1  synchronous kill: empties the output register and clears the hazard window
- in_valid  in  1  instr/rs_data/rt_data are valid
- in_ready  out  1  stage accepts this cycle (combinational)
- instr  in  32  MIPS instruction word
- rs_data  in  32  register-file value for instr[25:21]
- rt_data  in  32  register-file value for instr[20:16]
- out_valid  out  1  output register holds an issued instruction
- out_ready  in  1  ALU/EX consumer accepts this cycle
- reg1, reg2  out  32  ALU operands
- op_code  out  5  ALU op code, 0..20
- shamt  out  5  shift amount
- st_data  out  32  store data for sw (rt_data); 0 otherwise
- dst  out  5  write-back register
- wr_en  out  1  write-back enable
- mem_rd, mem_wr  out  1  lw / sw markers
- illegal  out  1  unrecognised encoding
- stall_cnt  out  STALL_W  saturating count of interlock cycles

## Operation
- R-type (opcode 0) funct map:
  - 20→0 add, 21→1 addu, 22→2 sub, 23→3 subu, 24→4 and, 25→5 or, 27→6 nor, 2A→7 slt, 00→8 sll, 02→9 srl, 03→10 sra, 08→11 jr.
  - Instruction word 0 maps to 12 (nop).
  - Operands: reg1=rs_data, reg2=rt_data, shamt=instr[10:6], dst=rd.
- I-type opcode map:
  - 0C→13 andi and 0D→14 ori: zero-extended immediate.
  - 0A→15 slti, 08→16 addi, 09→17 addiu, 23→18 lw, 2B→19 sw: sign-extended immediate.
  - 0F→20 lui: reg2 = zero-extended immediate; the ALU performs the shift.
  - Operands: reg1=rs_data, reg2=extended immediate, shamt=0, dst=rt.
- Any other encoding: op_code=12, illegal=1, wr_en=0, and all operands are 0.
- wr_en=0 for jr, sw, nop, illegal, and whenever dst==0.
- mem_rd=1 only for lw. mem_wr=1 only for sw. st_data=rt_data only for sw.
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - in_ready = !flush && !hazard && (!out_valid || out_ready). This gives full throughput: the stage can accept and issue in the same cycle.
  - Outputs stay stable while out_valid && !out_ready.
- Load-use interlock:
  - The hazard window is open while an lw with dst≠0 sits in the output register, and for exactly one cycle after that lw transfers out.
  - hazard = window open && in_valid && the incoming instruction reads the lw dst.
  - "Reads" means rs for all types except nop/illegal, and additionally rt for R-type and sw. For sll/srl/sra only rt is read.
  - A dependent instruction is therefore accepted no earlier than the second cycle after the lw transfers out.
- stall_cnt increments on every cycle in which hazard=1, and saturates at all-ones.
- flush takes priority over everything:
  - next cycle out_valid=0 and the hazard window is closed;
  - the instruction presented in the flush cycle is not accepted;
  - stall_cnt is not cleared and does not count the flush cycle.

## Timing
- Reset (async assert, synchronous release):
  - out_valid=0, op_code=12, and all other outputs 0;
  - stall_cnt=0 and the hazard window is closed.
- Latency: an instruction accepted at edge N is presented with out_valid=1 after edge N, i.e. one cycle.
- Back-to-back issue: when out_ready stays 1 and there is no hazard, one instruction issues per cycle.
- Simultaneous out-transfer and in-transfer in one cycle: the output register is replaced by the new instruction and out_valid stays 1.
- If reset asserts mid-hazard or mid-backpressure, all state is lost immediately and the stage does not replay anything.

## Test plan
- Reset → out_valid=0, op_code=12, stall_cnt=0. After release, addi $2,$1,-4 with rs_data=10 → next cycle op_code=16, reg1=10, reg2=FFFFFFFC, dst=2, wr_en=1.
- Decode coverage:
  - each of the 21 mapped encodings → its op_code;
  - lui imm=8000 → reg2=00008000, op 20;
  - ori imm=8000 → reg2=00008000;
  - opcode 3F → illegal=1, op 12.
- lw $5 then add $6,$5,$1 with out_ready=1 → the add is held off for 2 cycles (one cycle while the lw is in the output register, then the post-transfer window cycle), then issues; stall_cnt=2. Replacing the add with one that does not read $5 → no stall.
- out_ready=0 for 5 cycles with out_valid=1 → outputs stable, in_ready=0. Then out_ready=1 with a new instruction pending → transfer out and in occur in the same cycle.
- flush asserted while out_valid=1 and the hazard window is open → next cycle out_valid=0, the window is closed, and the presented instruction is dropped.
- Force 2^STALL_W+3 hazard cycles → stall_cnt holds all-ones.

Source files
------------

// File: rtl/alu_issue.sv
// Decode-and-issue stage in front of the ALU: MIPS word -> ALU op/operands,
// single-entry output register with valid/ready, one-cycle load-use interlock.
module alu_issue #(
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic [31:0]        rs_data,
    input  logic [31:0]        rt_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        reg1,
    output logic [31:0]        reg2,
    output logic [4:0]         op_code,
    output logic [4:0]         shamt,
    output logic [31:0]        st_data,
    output logic [4:0]         dst,
    output logic               wr_en,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               illegal,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SUBU  = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_NOR   = 5'd6;
    localparam logic [4:0] OP_SLT   = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_JR    = 5'd11;
    localparam logic [4:0] OP_NOP   = 5'd12;
    localparam logic [4:0] OP_ANDI  = 5'd13;
    localparam logic [4:0] OP_ORI   = 5'd14;
    localparam logic [4:0] OP_SLTI  = 5'd15;
    localparam logic [4:0] OP_ADDI  = 5'd16;
    localparam logic [4:0] OP_ADDIU = 5'd17;
    localparam logic [4:0] OP_LW    = 5'd18;
    localparam logic [4:0] OP_SW    = 5'd19;
    localparam logic [4:0] OP_LUI   = 5'd20;

    logic [5:0]  opc;
    logic [5:0]  funct;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [15:0] imm;

    assign opc   = instr[31:26];
    assign rs_f  = instr[25:21];
    assign rt_f  = instr[20:16];
    assign rd_f  = instr[15:11];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];

    logic [4:0]  d_op;
    logic [4:0]  d_sh;
    logic [4:0]  d_dst;
    logic [31:0] d_r1;
    logic [31:0] d_r2;
    logic [31:0] d_st;
    logic        d_ill;
    logic        d_mrd;
    logic        d_mwr;
    logic        d_wr;
    logic        use_rs;
    logic        use_rt;
    logic        no_wb;

    always_comb begin
        d_op   = OP_NOP;
        d_r1   = rs_data;
        d_r2   = rt_data;
        d_sh   = instr[10:6];
        d_dst  = rd_f;
        d_st   = '0;
        d_ill  = 1'b0;
        d_mrd  = 1'b0;
        d_mwr  = 1'b0;
        use_rs = 1'b1;
        use_rt = 1'b1;
        no_wb  = 1'b0;
        if (instr == 32'd0) begin
            use_rs = 1'b0;
            use_rt = 1'b0;
            no_wb  = 1'b1;
        end else if (opc == 6'h00) begin
            case (funct)
                6'h20: d_op = OP_ADD;
                6'h21: d_op = OP_ADDU;
                6'h22: d_op = OP_SUB;
                6'h23: d_op = OP_SUBU;
                6'h24: d_op = OP_AND;
                6'h25: d_op = OP_OR;
                6'h27: d_op = OP_NOR;
                6'h2A: d_op = OP_SLT;
                // shifts take their operand from rt only
                6'h00: begin d_op = OP_SLL; use_rs = 1'b0; end
                6'h02: begin d_op = OP_SRL; use_rs = 1'b0; end
                6'h03: begin d_op = OP_SRA; use_rs = 1'b0; end
                6'h08: begin d_op = OP_JR;  no_wb  = 1'b1; end
                default: d_ill = 1'b1;
            endcase
        end else begin
            d_r2   = {{16{imm[15]}}, imm};
            d_sh   = '0;
            d_dst  = rt_f;
            use_rt = 1'b0;
            case (opc)
                6'h0C: begin d_op = OP_ANDI; d_r2 = {16'h0, imm}; end
                6'h0D: begin d_op = OP_ORI;  d_r2 = {16'h0, imm}; end
                6'h0A: d_op = OP_SLTI;
                6'h08: d_op = OP_ADDI;
                6'h09: d_op = OP_ADDIU;
                6'h23: begin d_op = OP_LW; d_mrd = 1'b1; end
                6'h2B: begin
                    d_op   = OP_SW;
                    d_mwr  = 1'b1;
                    d_st   = rt_data;
                    use_rt = 1'b1;
                    no_wb  = 1'b1;
                end
                // ALU does the <<16; pass the raw immediate
                6'h0F: begin d_op = OP_LUI; d_r2 = {16'h0, imm}; end
                default: d_ill = 1'b1;
            endcase
        end
        if (d_ill) begin
            d_op   = OP_NOP;
            d_r1   = '0;
            d_r2   = '0;
            d_sh   = '0;
            d_dst  = '0;
            d_st   = '0;
            d_mrd  = 1'b0;
            d_mwr  = 1'b0;
            use_rs = 1'b0;
            use_rt = 1'b0;
            no_wb  = 1'b1;
        end
    end

    assign d_wr = !no_wb && (d_dst != 5'd0);

    // Load-use window: lw in the output register, plus one cycle after it leaves.
    logic       tail_open;
    logic [4:0] tail_dst;
    logic       cur_open;
    logic       hit_cur;
    logic       hit_tail;
    logic       hazard;
    logic       take;

    assign cur_open = out_valid && mem_rd && (dst != 5'd0);
    assign hit_cur  = cur_open && ((use_rs && rs_f == dst) || (use_rt && rt_f == dst));
    assign hit_tail = tail_open && ((use_rs && rs_f == tail_dst) || (use_rt && rt_f == tail_dst));
    assign hazard   = in_valid && (hit_cur || hit_tail);
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            op_code   <= OP_NOP;
            reg1      <= '0;
            reg2      <= '0;
            shamt     <= '0;
            st_data   <= '0;
            dst       <= '0;
            wr_en     <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (take) begin
            out_valid <= 1'b1;
            op_code   <= d_op;
            reg1      <= d_r1;
            reg2      <= d_r2;
            shamt     <= d_sh;
            st_data   <= d_st;
            dst       <= d_dst;
            wr_en     <= d_wr;
            mem_rd    <= d_mrd;
            mem_wr    <= d_mwr;
            illegal   <= d_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_open <= 1'b0;
            tail_dst  <= '0;
        end else begin
            tail_open <= !flush && cur_open && out_ready;
            tail_dst  <= dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hazard && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: reference decode + hazard model, directed
// corner cases followed by randomized traffic with back-pressure and flushes.
module tb_alu_issue;

    localparam int SW = 10;
    localparam logic [SW-1:0] SAT = '1;

    localparam logic [5:0] R_FUNCT [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                            6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h08};
    localparam logic [5:0] I_OPC   [8]  = '{6'h0C, 6'h0D, 6'h0A, 6'h08, 6'h09, 6'h23,
                                            6'h2B, 6'h0F};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instr = '0;
    logic [31:0]   rs_data = '0;
    logic [31:0]   rt_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   reg1, reg2, st_data;
    logic [4:0]    op_code, shamt, dst;
    logic          wr_en, mem_rd, mem_wr, illegal;
    logic [SW-1:0] stall_cnt;

    alu_issue #(.STALL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid),
        .out_ready(out_ready), .reg1(reg1), .reg2(reg2), .op_code(op_code), .shamt(shamt),
        .st_data(st_data), .dst(dst), .wr_en(wr_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .illegal(illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] st;
        logic [4:0]  op;
        logic [4:0]  sh;
        logic [4:0]  dst;
        logic        wr;
        logic        mrd;
        logic        mwr;
        logic        ill;
    } exp_t;

    // Reference decode straight from the op tables.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] a,
                                        input logic [31:0] b);
        exp_t e;
        int   op;
        e    = '0;
        e.op = 5'd12;
        op   = -1;
        if (w == 32'd0) begin
            e.r1 = a;
            e.r2 = b;
            return e;
        end
        if (w[31:26] == 6'h00) begin
            for (int i = 0; i < 12; i++) if (w[5:0] == R_FUNCT[i]) op = i;
            if (op >= 0) begin
                e.r1 = a; e.r2 = b; e.sh = w[10:6]; e.dst = w[15:11];
            end
        end else begin
            for (int i = 0; i < 8; i++) if (w[31:26] == I_OPC[i]) op = 13 + i;
            if (op >= 0) begin
                e.r1  = a;
                e.dst = w[20:16];
                if (op == 13 || op == 14 || op == 20) e.r2 = {16'h0, w[15:0]};
                else e.r2 = {{16{w[15]}}, w[15:0]};
            end
        end
        if (op < 0) begin
            e.ill = 1'b1;
            return e;
        end
        e.op  = 5'(op);
        e.mrd = (op == 18);
        e.mwr = (op == 19);
        e.st  = (op == 19) ? b : 32'd0;
        e.wr  = (op != 11) && (op != 19) && (e.dst != 5'd0);
        return e;
    endfunction

    function automatic logic reads(input logic [31:0] w, input logic [4:0] r);
        exp_t e;
        e = ref_decode(w, 32'd0, 32'd0);
        if (e.ill || w == 32'd0) return 1'b0;
        if (w[31:26] == 6'h00) begin
            if (e.op == 5'd8 || e.op == 5'd9 || e.op == 5'd10) return w[20:16] == r;
            return (w[25:21] == r) || (w[20:16] == r);
        end
        if (e.op == 5'd19) return (w[25:21] == r) || (w[20:16] == r);
        return w[25:21] == r;
    endfunction

    function automatic logic [31:0] rand_instr();
        int          k;
        logic [4:0]  a, b, c;
        logic [15:0] im;
        k  = $urandom_range(0, 25);
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        c  = 5'($urandom_range(0, 7));
        im = 16'($urandom);
        if (k < 12) return {6'h00, a, b, c, 5'($urandom), R_FUNCT[k]};
        if (k < 20) return {I_OPC[k-12], a, b, im};
        if (k == 20) return 32'd0;
        if (k == 21) return $urandom;
        return {6'h23, a, b, im};
    endfunction

    // Scoreboard push side and cycle-level model of ready/valid/stall.
    exp_t       sb[$];
    exp_t       m_out;
    logic       m_full;
    logic [4:0] m_tail;
    int         m_stall;

    always @(negedge clk) begin : push_blk
        exp_t d;
        logic haz, rdy;
        logic [4:0] nt;
        if (!rst_n) begin
            m_out = '0; m_full = 1'b0; m_tail = '0; m_stall = 0;
            sb.delete();
        end else begin
            d   = ref_decode(instr, rs_data, rt_data);
            haz = in_valid && ((m_full && m_out.mrd && m_out.dst != 5'd0 && reads(instr, m_out.dst))
                               || (m_tail != 5'd0 && reads(instr, m_tail)));
            rdy = !flush && !haz && (!m_full || out_ready);
            chk("in_ready", 32'(in_ready), 32'(rdy));
            chk("out_valid", 32'(out_valid), 32'(m_full));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            nt = (!flush && m_full && out_ready && m_out.mrd) ? m_out.dst : 5'd0;
            if (haz && !flush && m_stall < int'(SAT)) m_stall++;
            if (flush) begin
                m_full = 1'b0;
                sb.delete();
            end else if (in_valid && rdy) begin
                m_out  = d;
                m_full = 1'b1;
                sb.push_back(d);
            end else if (out_ready) begin
                m_full = 1'b0;
            end
            m_tail = nt;
        end
    end

    // Monitor: pop on every output transfer.
    always @(negedge clk) begin : mon_blk
        exp_t e;
        if (rst_n && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected op=%0d with empty scoreboard @%0t", op_code, $time);
            end else begin
                e = sb.pop_front();
                chk("o_op", 32'(op_code), 32'(e.op));
                chk("o_reg1", reg1, e.r1);
                chk("o_reg2", reg2, e.r2);
                chk("o_shamt", 32'(shamt), 32'(e.sh));
                chk("o_st", st_data, e.st);
                chk("o_dst", 32'(dst), 32'(e.dst));
                chk("o_wr", 32'(wr_en), 32'(e.wr));
                chk("o_mrd", 32'(mem_rd), 32'(e.mrd));
                chk("o_mwr", 32'(mem_wr), 32'(e.mwr));
                chk("o_ill", 32'(illegal), 32'(e.ill));
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                         output int waited);
        in_valid = 1'b1; instr = w; rs_data = a; rt_data = b;
        waited = 0;
        #1;
        while (!in_ready && waited < 2000) begin
            @(posedge clk);
            #2;
            waited++;
        end
        chk("issue_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    localparam logic [31:0] LW5   = {6'h23, 5'd1, 5'd5, 16'h0010};
    localparam logic [31:0] ADD65 = {6'h00, 5'd5, 5'd1, 5'd6, 5'd0, 6'h20};

    initial begin
        int w;
        int base;
        logic [31:0] w0, e2, s1, s2;
        logic [4:0]  sop;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op", 32'(op_code), 32'd12);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_reg1", reg1, 32'd0);
        chk("rst_dst", 32'(dst), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // addi $2,$1,-4
        issue({6'h08, 5'd1, 5'd2, 16'hFFFC}, 32'd10, 32'd0, w);
        chk("addi_op", 32'(op_code), 32'd16);
        chk("addi_reg1", reg1, 32'd10);
        chk("addi_reg2", reg2, 32'hFFFF_FFFC);
        chk("addi_dst", 32'(dst), 32'd2);
        chk("addi_wr", 32'(wr_en), 32'd1);

        // Every mapped encoding, immediates at the sign boundary
        for (int i = 0; i < 12; i++) begin
            w0 = {6'h00, 5'd3, 5'd4, 5'd7, 5'd5, R_FUNCT[i]};
            issue(w0, 32'hA5A5_0001, 32'h1234_5678, w);
            chk("dec_r_op", 32'(op_code), 32'(i));
            chk("dec_r_reg2", reg2, 32'h1234_5678);
            chk("dec_r_ill", 32'(illegal), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            w0 = {I_OPC[i], 5'd3, 5'd7, 16'h8000};
            e2 = (i == 0 || i == 1 || i == 7) ? 32'h0000_8000 : 32'hFFFF_8000;
            issue(w0, 32'hA5A5_0001, 32'h1234_5678, w);
            chk("dec_i_op", 32'(op_code), 32'(13 + i));
            chk("dec_i_reg2", reg2, e2);
            if (i == 6) begin
                chk("sw_st", st_data, 32'h1234_5678);
                chk("sw_wr", 32'(wr_en), 32'd0);
                chk("sw_mwr", 32'(mem_wr), 32'd1);
            end
        end
        issue(32'd0, 32'h1, 32'h2, w);
        chk("nop_op", 32'(op_code), 32'd12);
        chk("nop_wr", 32'(wr_en), 32'd0);
        issue({6'h3F, 5'd3, 5'd7, 16'h1234}, 32'h55, 32'h66, w);
        chk("ill_op", 32'(op_code), 32'd12);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_reg1", reg1, 32'd0);

        // Load-use: dependent add waits two cycles
        idle(2);
        base = int'(stall_cnt);
        issue(LW5, 32'd100, 32'd0, w);
        issue(ADD65, 32'd7, 32'd9, w);
        chk("lu_wait", 32'(w), 32'd2);
        chk("lu_stall", 32'(int'(stall_cnt) - base), 32'd2);
        chk("lu_op", 32'(op_code), 32'd0);
        idle(2);
        base = int'(stall_cnt);
        issue(LW5, 32'd100, 32'd0, w);
        issue({6'h00, 5'd7, 5'd1, 5'd6, 5'd0, 6'h20}, 32'd7, 32'd9, w);
        chk("nolu_wait", 32'(w), 32'd0);
        chk("nolu_stall", 32'(int'(stall_cnt) - base), 32'd0);

        // Back-pressure: outputs hold, then out+in transfer in one cycle
        idle(2);
        out_ready = 1'b0;
        issue({6'h0D, 5'd3, 5'd9, 16'h8000}, 32'h0F0F_0000, 32'd0, w);
        chk("ori_reg2", reg2, 32'h0000_8000);
        sop = op_code; s1 = reg1; s2 = reg2;
        in_valid = 1'b1;
        instr = {6'h00, 5'd3, 5'd4, 5'd10, 5'd0, 6'h22};
        rs_data = 32'd50; rt_data = 32'd8;
        repeat (5) begin
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_op", 32'(op_code), 32'(sop));
            chk("bp_reg1", reg1, s1);
            chk("bp_reg2", reg2, s2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_swap_valid", 32'(out_valid), 32'd1);
        chk("bp_swap_op", 32'(op_code), 32'd2);

        // Flush with lw in the output register and leaving this cycle
        idle(2);
        out_ready = 1'b0;
        issue(LW5, 32'd100, 32'd0, w);
        out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1;
        instr = {6'h00, 5'd3, 5'd4, 5'd8, 5'd0, 6'h25};
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; instr = ADD65;
        #1;
        chk("fl_window_closed", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("fl_next_op", 32'(op_code), 32'd0);
        chk("fl_next_dst", 32'(dst), 32'd6);

        // Randomized traffic
        idle(2);
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = rand_instr();
            rs_data   = $urandom;
            rt_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            @(posedge clk);
            #1;
        end

        // Saturation: hold a dependent add against a stuck lw
        idle(2);
        out_ready = 1'b0;
        issue(LW5, 32'd100, 32'd0, w);
        in_valid = 1'b1; instr = ADD65;
        repeat ((1 << SW) + 3) @(posedge clk);
        #1;
        chk("sat_cnt", 32'(stall_cnt), 32'(SAT));
        repeat (4) @(posedge clk);
        #1;
        chk("sat_hold", 32'(stall_cnt), 32'(SAT));

        idle(6);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
